// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler feeding a UART transmitter from a register-read
// channel (1 byte) and an ALU-result channel (2 bytes, LSB first).
module uart_tx_sched #(
  parameter int unsigned BUSY_TMO = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  output logic        rd_ack,
  input  logic        alu_valid,
  input  logic [15:0] alu_data,
  output logic        alu_ack,
  input  logic        tx_busy,
  output logic [7:0]  tx_p_data,
  output logic        tx_data_valid,
  output logic        sched_busy,
  output logic        tmo_err
);

  localparam int unsigned CW = (BUSY_TMO < 1) ? 1 : $clog2(BUSY_TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TMO - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;

  state_t        state;
  logic          rr_alu;
  logic          hi_pend;
  logic [7:0]    hi_byte;
  logic [CW-1:0] tmo_cnt;
  logic          gnt_alu;

  // ALU wins only when it is the sole requester or it was not granted last.
  assign gnt_alu    = alu_valid && (!rd_valid || rr_alu);
  assign sched_busy = (state != IDLE);

  // The launch strobe and byte are loaded on the transition into LAUNCH so the
  // strobe is high exactly while the FSM sits in LAUNCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rr_alu        <= 1'b0;
      hi_pend       <= 1'b0;
      hi_byte       <= '0;
      tmo_cnt       <= '0;
      rd_ack        <= 1'b0;
      alu_ack       <= 1'b0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      tmo_err       <= 1'b0;
    end else begin
      rd_ack        <= 1'b0;
      alu_ack       <= 1'b0;
      tx_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!tx_busy && (rd_valid || alu_valid)) begin
            state         <= LAUNCH;
            tx_data_valid <= 1'b1;
            if (gnt_alu) begin
              alu_ack   <= 1'b1;
              tx_p_data <= alu_data[7:0];
              hi_byte   <= alu_data[15:8];
              hi_pend   <= 1'b1;
              rr_alu    <= 1'b0;
            end else begin
              rd_ack    <= 1'b1;
              tx_p_data <= rd_data;
              hi_pend   <= 1'b0;
              rr_alu    <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          state   <= WAIT_HI;
          tmo_cnt <= '0;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (tmo_cnt >= TMO_LAST) begin
            tmo_err <= 1'b1;
            hi_pend <= 1'b0;
            state   <= IDLE;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (hi_pend) begin
              tx_p_data     <= hi_byte;
              tx_data_valid <= 1'b1;
              hi_pend       <= 1'b0;
              state         <= LAUNCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: behavioural UART busy model, queue-driven
// requesters, and hand-computed expected bytes, grant order and timing.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        rd_ack;
  logic        alu_valid = 1'b0;
  logic [15:0] alu_data = '0;
  logic        alu_ack;
  logic        tx_busy;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        sched_busy;
  logic        tmo_err;

  logic model_busy = 1'b0;
  logic busy_force = 1'b0;
  assign tx_busy = model_busy | busy_force;

  uart_tx_sched #(.BUSY_TMO(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_ack        (rd_ack),
    .alu_valid     (alu_valid),
    .alu_data      (alu_data),
    .alu_ack       (alu_ack),
    .tx_busy       (tx_busy),
    .tx_p_data     (tx_p_data),
    .tx_data_valid (tx_data_valid),
    .sched_busy    (sched_busy),
    .tmo_err       (tmo_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART model: busy rises hi_delay cycles after a strobe, lasts busy_len cycles.
  bit          respond  = 1'b1;
  int          hi_delay = 2;
  int          busy_len = 100;
  logic [7:0]  sent[$];
  int unsigned strobe_cyc[$];
  int unsigned fall_cyc[$];

  initial forever begin
    @(negedge clk);
    if (tx_data_valid) begin
      sent.push_back(tx_p_data);
      strobe_cyc.push_back(cyc);
      if (respond) begin
        repeat (hi_delay) @(negedge clk);
        model_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        model_busy = 1'b0;
        fall_cyc.push_back(cyc);
      end
    end
  end

  // Requesters hold valid until acked; also count strobes, acks and grant order.
  logic [7:0]  rd_q[$];
  logic [15:0] alu_q[$];
  int          grants[$];
  int          vcount = 0;
  int          rd_acks = 0;
  int          alu_acks = 0;

  initial forever begin
    @(negedge clk);
    if (tx_data_valid) vcount++;
    if (rd_ack) begin
      rd_acks++;
      grants.push_back(0);
      if (rd_q.size() > 0) void'(rd_q.pop_front());
    end
    if (alu_ack) begin
      alu_acks++;
      grants.push_back(1);
      if (alu_q.size() > 0) void'(alu_q.pop_front());
    end
    rd_valid  = (rd_q.size() > 0);
    rd_data   = (rd_q.size() > 0) ? rd_q[0] : 8'h00;
    alu_valid = (alu_q.size() > 0);
    alu_data  = (alu_q.size() > 0) ? alu_q[0] : 16'h0000;
  end

  function automatic logic [31:0] sent_at(input int i);
    return (i >= 0 && i < sent.size()) ? 32'(sent[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] grant_at(input int i);
    return (i >= 0 && i < grants.size()) ? 32'(grants[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] strobe_at(input int i);
    return (i >= 0 && i < strobe_cyc.size()) ? strobe_cyc[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] fall_at(input int i);
    return (i >= 0 && i < fall_cyc.size()) ? fall_cyc[i] : 32'h0;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (n < 3000 && (sched_busy || tx_busy || rd_q.size() > 0 || alu_q.size() > 0)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_strobe(input string tag, output int unsigned sc);
    int n = 0;
    @(negedge clk);
    while (n < 200 && !tx_data_valid) begin
      @(negedge clk);
      n++;
    end
    sc = cyc;
    check(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_ack"},  32'(rd_ack), 32'd0);
    check({tag, "_alu_ack"}, 32'(alu_ack), 32'd0);
    check({tag, "_valid"},   32'(tx_data_valid), 32'd0);
    check({tag, "_pdata"},   32'(tx_p_data), 32'd0);
    check({tag, "_busy"},    32'(sched_busy), 32'd0);
    check({tag, "_tmo"},     32'(tmo_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int fb;
    int s_v;
    int s_a;
    int s_r;
    int unsigned sc;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single register-read byte
    base = sent.size();
    s_v  = vcount;
    rd_q.push_back(8'hA5);
    wait_idle("t1_idle");
    check("t1_byte",   sent_at(base), 32'hA5);
    check("t1_rdacks", 32'(rd_acks), 32'd1);
    check("t1_strobe", 32'(vcount - s_v), 32'd1);
    check("t1_hold",   32'(tx_p_data), 32'hA5);
    check("t1_sbusy",  32'(sched_busy), 32'd0);

    // ALU word, LSB first, 1-cycle gap after busy falls
    base = sent.size();
    fb   = fall_cyc.size();
    s_v  = vcount;
    alu_q.push_back(16'h1234);
    wait_idle("t2_idle");
    check("t2_lsb",     sent_at(base), 32'h34);
    check("t2_msb",     sent_at(base + 1), 32'h12);
    check("t2_aluacks", 32'(alu_acks), 32'd1);
    check("t2_strobes", 32'(vcount - s_v), 32'd2);
    check("t2_gap",     strobe_at(base + 1) - fall_at(fb), 32'd1);

    // Both channels held: round-robin, ALU bytes contiguous
    base = sent.size();
    grants.delete();
    rd_q.push_back(8'h11);
    rd_q.push_back(8'h22);
    alu_q.push_back(16'hBBAA);
    alu_q.push_back(16'hDDCC);
    wait_idle("t3_idle");
    check("t3_ngrants", 32'(grants.size()), 32'd4);
    check("t3_g0", grant_at(0), 32'd0);
    check("t3_g1", grant_at(1), 32'd1);
    check("t3_g2", grant_at(2), 32'd0);
    check("t3_g3", grant_at(3), 32'd1);
    check("t3_b0", sent_at(base),     32'h11);
    check("t3_b1", sent_at(base + 1), 32'hAA);
    check("t3_b2", sent_at(base + 2), 32'hBB);
    check("t3_b3", sent_at(base + 3), 32'h22);
    check("t3_b4", sent_at(base + 4), 32'hCC);
    check("t3_b5", sent_at(base + 5), 32'hDD);

    // Transmitter already busy in IDLE: no grant until it drops
    busy_force = 1'b1;
    s_r  = rd_acks;
    base = sent.size();
    rd_q.push_back(8'h3C);
    repeat (6) @(negedge clk);
    check("t4_noack",  32'(rd_acks - s_r), 32'd0);
    check("t4_sbusy",  32'(sched_busy), 32'd0);
    busy_force = 1'b0;
    wait_idle("t4_idle");
    check("t4_byte",   sent_at(base), 32'h3C);

    // Busy never rises: timeout after 15 WAIT_HI cycles, then service resumes
    respond = 1'b0;
    rd_q.push_back(8'h5A);
    wait_strobe("t5_strobe", sc);
    while (cyc < sc + 15) @(negedge clk);
    check("t5_tmo_pre",   32'(tmo_err), 32'd0);
    check("t5_busy_pre",  32'(sched_busy), 32'd1);
    @(negedge clk);
    check("t5_tmo",       32'(tmo_err), 32'd1);
    check("t5_idle",      32'(sched_busy), 32'd0);
    respond = 1'b1;
    base = sent.size();
    rd_q.push_back(8'h77);
    wait_idle("t5_idle2");
    check("t5_next",      sent_at(base), 32'h77);
    check("t5_sticky",    32'(tmo_err), 32'd1);

    // Reset between the two ALU bytes
    base = sent.size();
    alu_q.push_back(16'h5678);
    wait_strobe("t6_strobe", sc);
    begin
      int n = 0;
      while (n < 50 && !tx_busy) begin
        @(negedge clk);
        n++;
      end
      check("t6_busy_seen", 32'(n < 50), 32'd1);
    end
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("t6_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s_v = vcount;
    s_a = alu_acks;
    repeat (250) @(negedge clk);
    check("t6_nostrobe", 32'(vcount - s_v), 32'd0);
    check("t6_noreack",  32'(alu_acks - s_a), 32'd0);
    check("t6_nbytes",   32'(sent.size() - base), 32'd1);
    check("t6_lsb",      sent_at(base), 32'h78);
    check("t6_pdata",    32'(tx_p_data), 32'd0);
    check("t6_sbusy",    32'(sched_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have parameter BUSY_TMO, default 15, meaning the max cycles to wait for tx_busy to rise after a byte is launched.
REQ-002 The block SHALL have port clk  input  1  single clock for all logic.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port rd_valid  input  1  channel 0 (register-read response) request.
REQ-005 The block SHALL have port rd_data  input  8  channel 0 byte.
REQ-006 The block SHALL have port rd_ack  output  1  one-cycle pulse: channel 0 request captured.
REQ-007 The block SHALL have port alu_valid  input  1  channel 1 (ALU result) request.
REQ-008 The block SHALL have port alu_data  input  16  channel 1 word, sent as two bytes.
REQ-009 The block SHALL have port alu_ack  output  1  one-cycle pulse: channel 1 request captured.
REQ-010 The block SHALL have port tx_busy  input  1  UART transmitter busy, already synchronised to clk outside this block.
REQ-011 The block SHALL have port tx_p_data  output  8  byte to UART transmitter.
REQ-012 The block SHALL have port tx_data_valid  output  1  one-cycle launch strobe to UART transmitter.
REQ-013 The block SHALL have port sched_busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 The block SHALL have port tmo_err  output  1  sticky flag: tx_busy failed to rise within BUSY_TMO cycles.

Function
REQ-015 The FSM SHALL have the states IDLE, LAUNCH, WAIT_HI, WAIT_LO.
REQ-016 In IDLE with tx_busy low and at least one valid, the block SHALL grant one channel, capture its data, pulse that channel's ack for the grant cycle, and go to LAUNCH.
REQ-017 Arbitration SHALL be round-robin: when both are valid, the channel not granted last wins; after reset, channel 0 has priority.
REQ-018 Channel 0 capture SHALL load a single-byte job; channel 1 capture SHALL load a two-byte job, alu_data[7:0] first and alu_data[15:8] second.
REQ-019 In LAUNCH, the block SHALL drive tx_p_data with the current byte and assert tx_data_valid for exactly one cycle, then go to WAIT_HI.
REQ-020 In WAIT_HI, tx_busy high SHALL move the FSM to WAIT_LO; if tx_busy stays low for BUSY_TMO cycles, the block SHALL set tmo_err, drop the rest of the job, and return to IDLE.
REQ-021 In WAIT_LO, when tx_busy falls, the FSM SHALL go to LAUNCH if a second byte is pending, otherwise to IDLE.
REQ-022 The gap between bytes of one ALU job SHALL be exactly 1 cycle from tx_busy low to the next tx_data_valid, and no other request SHALL be interleaved inside a job.
REQ-023 A valid asserted during a job SHALL be held by the requester until its ack; the block SHALL NOT ack while sched_busy is high.
REQ-024 tx_p_data SHALL hold its value from LAUNCH until the next LAUNCH.
REQ-025 The timeout counter SHALL be ceil(log2(BUSY_TMO+1)) bits wide, clear on entry to WAIT_HI, and saturate without wrapping.
REQ-026 If tx_busy is already high in IDLE, the block SHALL NOT grant until it is low.
REQ-027 tmo_err SHALL clear only on reset.

Reset
REQ-028 While rst is low, all outputs SHALL be 0, the FSM SHALL be IDLE, the job buffer SHALL be empty, and the round-robin pointer SHALL favour channel 0.
REQ-029 An rst assertion mid-job SHALL abort the job immediately, with no further tx_data_valid, and the aborted request SHALL NOT be re-acked.

Verification
REQ-030 Stimulus: rd_valid=1, rd_data=0xA5, tx_busy rises 2 cycles after the strobe and falls 100 cycles later. Response: rd_ack 1 cycle, tx_data_valid 1 cycle with tx_p_data=0xA5, then IDLE.
REQ-031 Stimulus: alu_valid with alu_data=0x1234. Response: bytes 0x34 then 0x12, with the second strobe 1 cycle after tx_busy falls.
REQ-032 Stimulus: rd_valid and alu_valid held high together for three jobs. Response: grant order ch0, ch1, ch0, and ALU bytes are never split by ch0.
REQ-033 Stimulus: tx_busy tied low after launch. Response: tmo_err=1 after 15 cycles, FSM back to IDLE, and the next request is served.
REQ-034 Stimulus: rst pulsed low between the two ALU bytes. Response: all outputs 0 and no MSB byte sent after reset release.
